rom_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the single-port memory slave (built clocked, one-cycle registered read data). It accepts read/write requests from two independent masters, such as the APB slave front-end and the Enigma rotor-lookup engine. It grants one request at a time and drives the memory's chip-select/op/address/wdata for exactly one cycle. It then returns the captured read data to the granted requester with a one-cycle response pulse.

---
 rtl/rom_arbiter_if.sv | 32 +++
 rtl/rom_arbiter.sv | 130 +++++++++++++
 tb/tb_rom_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/rom_arbiter_if.sv
// Bundle of requester handshake and memory-port signals around rom_arbiter.
// slave is the arbiter's view; master is the surrounding requesters + memory.
interface rom_arbiter_if #(
    parameter int unsigned ATW   = 5,
    parameter int unsigned DATAW = 32
);
    logic [1:0]         req_valid;
    logic [1:0]         req_op;
    logic [2*ATW-1:0]   req_addr;
    logic [2*DATAW-1:0] req_wdata;
    logic [1:0]         req_ready;
    logic [1:0]         rsp_valid;
    logic [DATAW-1:0]   rsp_rdata;
    logic               busy;
    logic               mem_cs;
    logic               mem_op;
    logic [ATW-1:0]     mem_address;
    logic [DATAW-1:0]   mem_wdata;
    logic [DATAW-1:0]   mem_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, busy,
               mem_cs, mem_op, mem_address, mem_wdata
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, busy,
               mem_cs, mem_op, mem_address, mem_wdata
    );
endinterface

// File: rtl/rom_arbiter.sv
// Two-requester arbiter/sequencer for a single-port registered-read memory.
// Define ROM_ARB_RR_EN for round-robin contention; default is fixed priority (requester 0).
module rom_arbiter #(
    parameter int unsigned ATW   = 5,
    parameter int unsigned DATAW = 32
) (
    input logic          mem_clk,
    input logic          mem_rst,
    rom_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e             state_q, state_d;
    logic               grant_q, grant_d;
    logic               op_q, op_d;
    logic [1:0]         req_ready_q, req_ready_d;
    logic [1:0]         rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;
    logic               mem_cs_q, mem_cs_d;
    logic               mem_op_q, mem_op_d;
    logic [ATW-1:0]     mem_address_q, mem_address_d;
    logic [DATAW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATAW-1:0]   rdata_hold_q, rdata_hold_d;
    logic [DATAW-1:0]   resp_data;
    logic               win;

`ifdef ROM_ARB_RR_EN
    logic ptr_q, ptr_d;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        if (&bus.req_valid) win = ~ptr_q;
        else                win = ~bus.req_valid[0];
    end
`else
    always_comb win = ~bus.req_valid[0];
`endif

    // Memory data is already registered, so it is forwarded straight through in RESP.
    assign resp_data = op_q ? '0 : bus.mem_rdata;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        op_d          = op_q;
        req_ready_d   = 2'b00;
        rsp_valid_d   = 2'b00;
        busy_d        = 1'b0;
        mem_cs_d      = 1'b0;
        mem_op_d      = 1'b0;
        mem_address_d = '0;
        mem_wdata_d   = '0;
        rdata_hold_d  = rdata_hold_q;
`ifdef ROM_ARB_RR_EN
        ptr_d         = ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (|bus.req_valid) begin
                    state_d       = StIssue;
                    grant_d       = win;
                    op_d          = bus.req_op[win];
                    req_ready_d   = win ? 2'b10 : 2'b01;
                    busy_d        = 1'b1;
                    mem_cs_d      = 1'b1;
                    mem_op_d      = bus.req_op[win];
                    mem_address_d = win ? bus.req_addr[2*ATW-1:ATW] : bus.req_addr[ATW-1:0];
                    mem_wdata_d   = win ? bus.req_wdata[2*DATAW-1:DATAW]
                                        : bus.req_wdata[DATAW-1:0];
`ifdef ROM_ARB_RR_EN
                    ptr_d         = win;
`endif
                end
            end
            StIssue: begin
                state_d     = StResp;
                rsp_valid_d = grant_q ? 2'b10 : 2'b01;
                busy_d      = 1'b1;
            end
            StResp: begin
                state_d      = StIdle;
                rdata_hold_d = resp_data;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            state_q       <= StIdle;
            grant_q       <= 1'b0;
            op_q          <= 1'b0;
            req_ready_q   <= 2'b00;
            rsp_valid_q   <= 2'b00;
            busy_q        <= 1'b0;
            mem_cs_q      <= 1'b0;
            mem_op_q      <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            rdata_hold_q  <= '0;
`ifdef ROM_ARB_RR_EN
            ptr_q         <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            op_q          <= op_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            busy_q        <= busy_d;
            mem_cs_q      <= mem_cs_d;
            mem_op_q      <= mem_op_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_hold_q  <= rdata_hold_d;
`ifdef ROM_ARB_RR_EN
            ptr_q         <= ptr_d;
`endif
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = (state_q == StResp) ? resp_data : rdata_hold_q;
    assign bus.busy        = busy_q;
    assign bus.mem_cs      = mem_cs_q;
    assign bus.mem_op      = mem_op_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a small registered-read memory model.
module tb_rom_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;
    logic [31:0] mem [32];
    logic [1:0]  exp_g;

    rom_arbiter_if #(.ATW(5), .DATAW(32)) bus ();

    rom_arbiter #(.ATW(5), .DATAW(32)) dut (
        .mem_clk (clk),
        .mem_rst (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_cs) begin
            if (bus.mem_op) mem[bus.mem_address] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_address];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_outs(input string tag);
        chk({tag, " req_ready"}, 64'(bus.req_ready), 64'd0);
        chk({tag, " rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, " busy"}, 64'(bus.busy), 64'd0);
        chk({tag, " mem_cs"}, 64'(bus.mem_cs), 64'd0);
        chk({tag, " mem_address"}, 64'(bus.mem_address), 64'd0);
        chk({tag, " mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[1] = 32'h0000AAAA;
        mem[2] = 32'h0000BBBB;
        mem[3] = 32'hDEADBEEF;
        bus.req_valid = 2'b00;
        bus.req_op    = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        tick(); tick();
        rst = 1'b0;
        idle_outs("reset");
        chk("reset rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("reset mem_op", 64'(bus.mem_op), 64'd0);

        // Single read by requester 1 from addr 3
        bus.req_valid = 2'b10; bus.req_op = 2'b00; bus.req_addr = {5'd3, 5'd0};
        tick();
        chk("rd1 req_ready", 64'(bus.req_ready), 64'h2);
        chk("rd1 mem_cs", 64'(bus.mem_cs), 64'd1);
        chk("rd1 mem_op", 64'(bus.mem_op), 64'd0);
        chk("rd1 mem_address", 64'(bus.mem_address), 64'd3);
        chk("rd1 busy", 64'(bus.busy), 64'd1);
        bus.req_valid = 2'b00;
        tick();
        chk("rd1 rsp_valid", 64'(bus.rsp_valid), 64'h2);
        chk("rd1 rsp_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);
        chk("rd1 busy n+2", 64'(bus.busy), 64'd1);
        chk("rd1 mem_cs n+2", 64'(bus.mem_cs), 64'd0);
        tick();
        idle_outs("rd1 n+3");
        chk("rd1 rdata hold", 64'(bus.rsp_rdata), 64'hDEADBEEF);

        // Requester 0 writes addr 7, then reads it back
        bus.req_valid = 2'b01; bus.req_op = 2'b01; bus.req_addr = {5'd0, 5'd7};
        bus.req_wdata = {32'h0, 32'h12345678};
        tick();
        chk("wr req_ready", 64'(bus.req_ready), 64'h1);
        chk("wr mem_op", 64'(bus.mem_op), 64'd1);
        chk("wr mem_address", 64'(bus.mem_address), 64'd7);
        chk("wr mem_wdata", 64'(bus.mem_wdata), 64'h12345678);
        bus.req_valid = 2'b00;
        tick();
        chk("wr rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("wr rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        tick();
        bus.req_valid = 2'b01; bus.req_op = 2'b00;
        tick();
        chk("rd7 req_ready", 64'(bus.req_ready), 64'h1);
        bus.req_valid = 2'b00;
        tick();
        chk("rd7 rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("rd7 rsp_rdata", 64'(bus.rsp_rdata), 64'h12345678);
        tick();

        // Contention from a fresh reset: both read continuously
        rst = 1'b1; tick(); rst = 1'b0;
        bus.req_valid = 2'b11; bus.req_op = 2'b00; bus.req_addr = {5'd2, 5'd1};
        for (int k = 0; k < 4; k++) begin
`ifdef ROM_ARB_RR_EN
            exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
            tick();
            chk($sformatf("cont%0d req_ready", k), 64'(bus.req_ready), 64'(exp_g));
            tick();
            chk($sformatf("cont%0d rsp_valid", k), 64'(bus.rsp_valid), 64'(exp_g));
            chk($sformatf("cont%0d rsp_rdata", k), 64'(bus.rsp_rdata),
                (exp_g == 2'b10) ? 64'hBBBB : 64'hAAAA);
            tick();
            chk($sformatf("cont%0d idle ready", k), 64'(bus.req_ready), 64'd0);
            chk($sformatf("cont%0d idle busy", k), 64'(bus.busy), 64'd0);
        end
        bus.req_valid = 2'b00;
        tick(); tick(); tick();

        // Reset asserted during the mem_cs cycle
        bus.req_valid = 2'b01;
        tick();
        chk("rstiss mem_cs", 64'(bus.mem_cs), 64'd1);
        rst = 1'b1; bus.req_valid = 2'b00;
        tick();
        idle_outs("rstiss after");
        rst = 1'b0;
        tick();
        chk("rstiss no rsp", 64'(bus.rsp_valid), 64'd0);
        bus.req_valid = 2'b10;
        tick();
        chk("post-rst req_ready", 64'(bus.req_ready), 64'h2);
        chk("post-rst mem_address", 64'(bus.mem_address), 64'd2);
        bus.req_valid = 2'b00;
        tick();
        chk("post-rst rsp_valid", 64'(bus.rsp_valid), 64'h2);
        chk("post-rst rsp_rdata", 64'(bus.rsp_rdata), 64'hBBBB);
        tick();

        // Requester 1 pulses valid for one cycle while requester 0 is in flight
        bus.req_valid = 2'b01;
        tick();
        chk("wd r0 ready", 64'(bus.req_ready), 64'h1);
        bus.req_valid = 2'b10;
        tick();
        chk("wd r0 rsp", 64'(bus.rsp_valid), 64'h1);
        bus.req_valid = 2'b00;
        tick();
        idle_outs("wd idle1");
        tick();
        idle_outs("wd idle2");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: run did not complete, observed running expected done");
        $fatal(1, "timeout");
    end
endmodule
